// File: rtl/reg_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// reg_writeback_arbiter
//
// Purpose: merges the single-cycle ALU/load result path (primary) and the
// long-latency mul/div result path (secondary, buffered in a small in-order
// FIFO) onto the register file's single write port. Primary always wins; a
// starvation counter raises stall_req so the pipeline can give queued
// secondary writes a slot.
//
// Ports:
//   clk                - system clock, rising edge
//   reset              - asynchronous, active-low reset
//   pri_valid/addr/data- primary write request (always accepted)
//   sec_valid/ready    - secondary handshake, transfer on valid & ready
//   sec_addr/data      - secondary write request
//   regWrite           - registered write enable to register file
//   reg_write_address  - registered write address
//   data_wb            - registered write data
//   stall_req          - registered request to hold pri_valid low
//   fifo_count         - current secondary FIFO occupancy
//
// Optional feature (macro WB_PENDING_EN): adds rd_addr1/rd_addr2 inputs and
// combinational pending1/pending2 outputs flagging reads of registers whose
// write is still queued or being presented on the write port.
// ---------------------------------------------------------------------------
module reg_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pri_valid,
  input  logic [4:0]       pri_addr,
  input  logic [31:0]      pri_data,
  input  logic             sec_valid,
  output logic             sec_ready,
  input  logic [4:0]       sec_addr,
  input  logic [31:0]      sec_data,
  output logic             regWrite,
  output logic [4:0]       reg_write_address,
  output logic [31:0]      data_wb,
  output logic             stall_req,
`ifdef WB_PENDING_EN
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  output logic             pending1,
  output logic             pending2,
`endif
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       memAddr_q [DEPTH];
  logic [31:0]      memData_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             regWrite_q, regWrite_d;
  logic [4:0]       wbAddr_q, wbAddr_d;
  logic [31:0]      wbData_q, wbData_d;
  logic             stall_q, stall_d;
  logic             fifoEmpty;
  logic             push;
  logic             pop;

  // Readiness depends only on the registered count, so a pop in the same
  // cycle as a full FIFO frees the slot only from the following cycle.
  assign sec_ready         = (count_q < CNT_W'(DEPTH));
  assign fifo_count        = count_q;
  assign regWrite          = regWrite_q;
  assign reg_write_address = wbAddr_q;
  assign data_wb           = wbData_q;
  assign stall_req         = stall_q;

  // Arbitration and next-state logic. Any primary request (even one to r0,
  // which produces no write) occupies the slot and blocks the FIFO. Writes
  // to r0 from the secondary side are handshaken but dropped. The empty test
  // uses the registered count, so a fresh push cannot pop in the same cycle.
  always_comb begin
    fifoEmpty  = (count_q == '0);
    push       = sec_valid && sec_ready && (sec_addr != 5'd0);
    pop        = !pri_valid && !fifoEmpty;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    wrPtr_d    = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d    = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    regWrite_d = 1'b0;
    wbAddr_d   = wbAddr_q;
    wbData_d   = wbData_q;
    starve_d   = starve_q;

    if (pri_valid && (pri_addr != 5'd0)) begin
      regWrite_d = 1'b1;
      wbAddr_d   = pri_addr;
      wbData_d   = pri_data;
    end else if (pop) begin
      regWrite_d = 1'b1;
      wbAddr_d   = memAddr_q[rdPtr_q];
      wbData_d   = memData_q[rdPtr_q];
    end

    // A non-empty FIFO that did not pop has lost the slot to the primary.
    if (pop || fifoEmpty) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end

    stall_d = (starve_d == SW'(STARVE_LIMIT)) && (count_d != '0);
  end

  // Control and write-port registers, cleared asynchronously so a write in
  // flight disappears the moment reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      regWrite_q <= 1'b0;
      wbAddr_q   <= '0;
      wbData_q   <= '0;
      stall_q    <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      regWrite_q <= regWrite_d;
      wbAddr_q   <= wbAddr_d;
      wbData_q   <= wbData_d;
      stall_q    <= stall_d;
    end
  end

  // FIFO storage needs no reset; entries are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      memAddr_q[wrPtr_q] <= sec_addr;
      memData_q[wrPtr_q] <= sec_data;
    end
  end

`ifdef WB_PENDING_EN
  logic [PTR_W-1:0] offset;

  // A register is pending if it is the target of any live FIFO entry (its
  // distance from the read pointer is below the occupancy) or it is the
  // write currently presented to the register file. r0 is never pending.
  always_comb begin
    pending1 = regWrite_q && (wbAddr_q == rd_addr1);
    pending2 = regWrite_q && (wbAddr_q == rd_addr2);
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rdPtr_q;
      if (CNT_W'(offset) < count_q) begin
        if (memAddr_q[i] == rd_addr1) pending1 = 1'b1;
        if (memAddr_q[i] == rd_addr2) pending2 = 1'b1;
      end
    end
    if (rd_addr1 == 5'd0) pending1 = 1'b0;
    if (rd_addr2 == 5'd0) pending2 = 1'b0;
  end
`endif

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback_arbiter
//
// Self-checking bench for reg_writeback_arbiter. A behavioural model keeps
// the secondary FIFO contents, starvation count and last write; each driven
// cycle pushes the write expected on the port into a scoreboard queue which
// is popped and compared once the DUT has clocked. Also exercises
// WB_PENDING_EN when that macro is defined.
// ---------------------------------------------------------------------------
module tb_reg_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pri_valid;
  logic [4:0]  pri_addr;
  logic [31:0] pri_data;
  logic        sec_valid;
  logic        sec_ready;
  logic [4:0]  sec_addr;
  logic [31:0] sec_data;
  logic        regWrite;
  logic [4:0]  reg_write_address;
  logic [31:0] data_wb;
  logic        stall_req;
  logic [2:0]  fifo_count;
`ifdef WB_PENDING_EN
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        pending1;
  logic        pending2;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [36:0] expQ[$];
  logic [36:0] mFifo[$];
  int          mStarve;
  logic        expStall;
  logic        lastWr;
  logic [4:0]  lastAddr;
  logic [31:0] lastData;

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  reg_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .pri_valid(pri_valid),
    .pri_addr(pri_addr),
    .pri_data(pri_data),
    .sec_valid(sec_valid),
    .sec_ready(sec_ready),
    .sec_addr(sec_addr),
    .sec_data(sec_data),
    .regWrite(regWrite),
    .reg_write_address(reg_write_address),
    .data_wb(data_wb),
    .stall_req(stall_req),
`ifdef WB_PENDING_EN
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .pending1(pending1),
    .pending2(pending2),
`endif
    .fifo_count(fifo_count)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Resets the behavioural model to its post-reset state.
  task automatic clearModel();
    mFifo.delete();
    expQ.delete();
    mStarve  = 0;
    expStall = 1'b0;
    lastWr   = 1'b0;
    lastAddr = '0;
    lastData = '0;
  endtask

`ifdef WB_PENDING_EN
  function automatic logic modelPending(input logic [4:0] a);
    logic hit;
    hit = lastWr && (lastAddr == a);
    foreach (mFifo[i]) if (mFifo[i][36:32] == a) hit = 1'b1;
    return (a != 5'd0) && hit;
  endfunction
`endif

  // Compares the DUT write port and status against the scoreboard after an edge.
  task automatic checkWrite();
    logic [36:0] e;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("regWrite", 32'(regWrite), 32'd1);
      lastWr   = 1'b1;
      lastAddr = e[36:32];
      lastData = e[31:0];
    end else begin
      checkOutput("regWriteIdle", 32'(regWrite), 32'd0);
      lastWr = 1'b0;
    end
    checkOutput("wbAddr", 32'(reg_write_address), 32'(lastAddr));
    checkOutput("wbData", data_wb, lastData);
    checkOutput("stallReq", 32'(stall_req), 32'(expStall));
`ifdef WB_PENDING_EN
    checkOutput("pending1", 32'(pending1), 32'(modelPending(rd_addr1)));
    checkOutput("pending2", 32'(pending2), 32'(modelPending(rd_addr2)));
`endif
  endtask

  // Drives one cycle of stimulus, predicts its effect, then clocks and checks.
  task automatic applyStimulus(input logic pv, input logic [4:0] pa,
                               input logic [31:0] pd, input logic sv,
                               input logic [4:0] sa, input logic [31:0] sd);
    logic ready;
    logic wasEmpty;
    logic mPop;
    pri_valid = pv;
    pri_addr  = pa;
    pri_data  = pd;
    sec_valid = sv;
    sec_addr  = sa;
    sec_data  = sd;
    ready     = (mFifo.size() < 4);
    wasEmpty  = (mFifo.size() == 0);
    mPop      = 1'b0;
    checkOutput("secReady", 32'(sec_ready), 32'(ready));
    checkOutput("fifoCount", 32'(fifo_count), 32'(mFifo.size()));
    if (pv && (pa != 5'd0)) begin
      expQ.push_back({pa, pd});
    end else if (!pv && !wasEmpty) begin
      expQ.push_back(mFifo.pop_front());
      mPop = 1'b1;
    end
    if (mPop || wasEmpty) mStarve = 0;
    else if (mStarve < 8) mStarve++;
    if (sv && ready && (sa != 5'd0)) mFifo.push_back({sa, sd});
    expStall = (mStarve == 8) && (mFifo.size() != 0);
    @(posedge clk);
    #1;
    checkWrite();
  endtask

  initial begin
    clearModel();
    reset     = 1'b0;
    pri_valid = 1'b1;
    pri_addr  = 5'd5;
    pri_data  = 32'hDEADBEEF;
    sec_valid = 1'b0;
    sec_addr  = '0;
    sec_data  = '0;
`ifdef WB_PENDING_EN
    rd_addr1  = 5'd12;
    rd_addr2  = 5'd0;
`endif

    // Reset holds everything at zero even with a primary request present.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstRegWrite", 32'(regWrite), 32'd0);
    checkOutput("rstAddr", 32'(reg_write_address), 32'd0);
    checkOutput("rstData", data_wb, 32'd0);
    checkOutput("rstSecReady", 32'(sec_ready), 32'd1);
    checkOutput("rstCount", 32'(fifo_count), 32'd0);
    checkOutput("rstStall", 32'(stall_req), 32'd0);
    reset = 1'b1;

    // Primary path: one write, then idle.
    applyStimulus(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Fill the FIFO under continuous primary traffic until stall_req rises.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 5'd1, 32'hA0 + i, 1'b1, 5'(8 + i), 32'h80 + i);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 5'd1, 32'hB0 + i, 1'b1, 5'd13, 32'h84);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Simultaneous push and pop with two entries queued.
    applyStimulus(1'b1, 5'd2, 32'hC0, 1'b1, 5'd14, 32'h14);
    applyStimulus(1'b1, 5'd2, 32'hC1, 1'b1, 5'd15, 32'h15);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h20);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Register-zero writes from both sources produce nothing.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Queue a write to r12 behind primary traffic, then drain it.
    applyStimulus(1'b1, 5'd4, 32'hD0, 1'b1, 5'd12, 32'hC0C0);
    applyStimulus(1'b1, 5'd5, 32'hD1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Randomised mix of both sources.
    for (int i = 0; i < 80; i++)
      applyStimulus(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);

    // Reset mid-operation: a presented write and queued entries vanish at once.
    applyStimulus(1'b1, 5'd6, 32'hE0, 1'b1, 5'd21, 32'h21);
    applyStimulus(1'b1, 5'd7, 32'hE1, 1'b1, 5'd22, 32'h22);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midRstRegWrite", 32'(regWrite), 32'd0);
    checkOutput("midRstAddr", 32'(reg_write_address), 32'd0);
    checkOutput("midRstCount", 32'(fifo_count), 32'd0);
    clearModel();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
Write-side front end for the 32x32 register file. It merges two result producers into the register file's single write port (regWrite / reg_write_address / data_wb), one write per cycle:
- Primary source: the single-cycle ALU/load path. Always accepted.
- Secondary source: long-latency units (mul/div). Valid/ready handshake, buffered in a small FIFO.

Write arbitration and starvation control live here so the register file stays a plain storage array.

Parameters:
DEPTH, 4, secondary FIFO entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive cycles the FIFO head may lose arbitration before stall_req asserts
CNT_W, 3, width of fifo_count (clog2(DEPTH)+1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
pri_valid  input  1  primary write request this cycle
pri_addr  input  5  primary destination register
pri_data  input  32  primary write data
sec_valid  input  1  secondary request valid
sec_ready  output  1  secondary request accepted when valid&ready
sec_addr  input  5  secondary destination register
sec_data  input  32  secondary write data
regWrite  output  1  write enable to register file
reg_write_address  output  5  write address to register file
data_wb  output  32  write data to register file
stall_req  output  1  asks the pipeline to hold pri_valid low next cycle
fifo_count  output  CNT_W  current FIFO occupancy

Behaviour:
Reset and timing
- While reset=0, asynchronously: regWrite=0, reg_write_address=0, data_wb=0, stall_req=0, FIFO emptied (pointers=0, count=0), starve counter=0.
- All outputs except sec_ready are registered. Latency from accepted request to regWrite is 1 cycle.

Output arbitration (per cycle)
- If pri_valid=1 and pri_addr!=0: issue the primary write next cycle.
- Else if pri_valid=1 and pri_addr=0: regWrite=0 next cycle. No pop; the slot counts as primary-occupied.
- Else if FIFO not empty: pop the head and issue it next cycle.
- Else: regWrite=0. reg_write_address and data_wb hold their last values.

Secondary enqueue
- sec_ready = (count < DEPTH). This is combinational from registered count only.
- Transfer occurs when sec_valid & sec_ready.
- If sec_addr=0, the transfer is accepted but not enqueued; the write is discarded.
- A push to an empty FIFO is not visible for pop until the next cycle. There is no same-cycle bypass.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: sec_ready=0. A same-cycle pop does not raise sec_ready until the following cycle.
- Pointers wrap modulo DEPTH.

Starvation control
- Starve counter increments each cycle the FIFO is non-empty and a primary request wins. It saturates at STARVE_LIMIT.
- The counter clears on any pop, or whenever the FIFO is empty.
- stall_req (registered) = 1 when counter == STARVE_LIMIT and the FIFO is non-empty; 0 otherwise.
- If pri_valid is still 1 while stall_req=1, primary still wins. stall_req stays high until a pop.

Ordering
- The FIFO is strictly in order.
- No WAW check is made between primary and queued writes. The hazard unit upstream guarantees that no two in-flight writes target the same register.

Reset mid-operation
- All queued writes are lost.
- Any write being presented on regWrite drops to 0 immediately.

Optional Feature:
Macro: WB_PENDING_EN
- Defined:
  - Adds inputs rd_addr1[4:0] and rd_addr2[4:0].
  - Adds outputs pending1 and pending2.
  - pendingN is combinational and =1 when rd_addrN != 0 and either: it matches the address of any valid FIFO entry, or it equals reg_write_address while regWrite=1.
  - Used by decode to stall on reads of not-yet-written results.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Reset check: hold reset=0 while pri_valid=1, pri_addr=5, pri_data=0xDEADBEEF -> regWrite=0, reg_write_address=0, data_wb=0, sec_ready=1, fifo_count=0.
2. Primary path: release reset, then pri_valid=1, addr=3, data=0x12345678 for 1 cycle -> next cycle regWrite=1, addr=3, data=0x12345678; the cycle after, regWrite=0.
3. Fill FIFO: push 4 secondary writes (addr 8..11, data 0x80..0x83) while pri_valid=1 continuously with addr=1 ->
   - fifo_count=4, sec_ready=0.
   - A 5th sec_valid is not accepted.
   - After 8 blocked cycles, stall_req=1.
   - Once pri_valid drops, writes to 8,9,10,11 appear in order on consecutive cycles; stall_req clears after the first pop.
4. Simultaneous push/pop: FIFO holds 2 entries, pri_valid=0, sec_valid=1 with addr=20 -> fifo_count stays 2; addr 20 is written 2 cycles after the currently queued head.
5. Register-zero writes: sec_valid=1 with sec_addr=0 and data=0xFFFFFFFF -> accepted, fifo_count unchanged, no regWrite. pri_valid=1 with pri_addr=0 -> regWrite=0.
6. Pending lookup (WB_PENDING_EN only): queue a write to addr 12, set rd_addr1=12 -> pending1=1 until the cycle after addr 12 appears on regWrite, then 0. rd_addr2=0 -> pending2=0 throughout.
